// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one seconds-countdown timer among N requesters.
// Optional feature macro: TIMER_ARB_CANCEL_EN (owner dropping req in RUN aborts the countdown).
module timer_arbiter #(
    parameter int N  = 4,
    parameter int TW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*TW-1:0] req_time,
    output logic [N-1:0]    grant,
    output logic [N-1:0]    done,
    output logic [N-1:0]    aborted,
    output logic            busy,
    output logic            tmr_load,
    output logic [TW-1:0]   tmr_time,
    output logic            tmr_clr,
    input  logic            tmr_timeout,
    output logic [2:0]      o_dbg_state
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_FLUSH, S_CLEAR, S_IDLE, S_LOAD, S_RUN, S_ABORT, S_DONE
    } state_t;

    // Remembers which path led into CLEAR, so CLEAR knows where to go and what to pulse.
    typedef enum logic [1:0] {SRC_FLUSH, SRC_RUN, SRC_ABORT} src_t;

    state_t        r_state, w_next;
    src_t          r_src;
    logic [IW-1:0] r_own, r_last, w_sel;
    logic [TW-1:0] r_t_lat, w_sel_time;
    logic [N-1:0]  w_own_oh;
    logic          w_found, w_cancel;

    always_comb begin : p_rr
        logic [IW-1:0] idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(r_last) + i) % N);
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
    end

    assign w_sel_time  = req_time[int'(w_sel)*TW +: TW];
    assign w_own_oh    = N'(1) << r_own;
    assign o_dbg_state = r_state;

`ifdef TIMER_ARB_CANCEL_EN
    assign w_cancel = ~req[r_own];
`else
    assign w_cancel = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FLUSH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FLUSH: w_next = S_CLEAR;
            S_CLEAR: w_next = (r_src == SRC_RUN) ? S_DONE : S_IDLE;
            S_IDLE:  if (w_found) w_next = (w_sel_time == '0) ? S_DONE : S_LOAD;
            S_LOAD:  w_next = S_RUN;
            // Timeout has priority over a simultaneous cancel.
            S_RUN:   if (tmr_timeout) w_next = S_CLEAR;
                     else if (w_cancel) w_next = S_ABORT;
            S_ABORT: w_next = S_CLEAR;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_FLUSH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src   <= SRC_FLUSH;
            r_own   <= '0;
            r_last  <= IW'(N - 1);
            r_t_lat <= '0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_own   <= w_sel;
                r_t_lat <= w_sel_time;
            end
            if (r_state == S_RUN && tmr_timeout) r_src <= SRC_RUN;
            if (r_state == S_ABORT) begin
                r_src  <= SRC_ABORT;
                r_last <= r_own;
            end
            if (r_state == S_DONE) r_last <= r_own;
        end
    end

    always_comb begin
        grant    = '0;
        done     = '0;
        aborted  = '0;
        busy     = 1'b1;
        tmr_load = 1'b0;
        tmr_time = '0;
        tmr_clr  = 1'b0;
        case (r_state)
            S_FLUSH: tmr_load = 1'b1;
            S_CLEAR: begin
                tmr_clr = 1'b1;
                if (r_src == SRC_RUN) grant = w_own_oh;
`ifdef TIMER_ARB_CANCEL_EN
                if (r_src == SRC_ABORT) aborted = w_own_oh;
`endif
            end
            S_IDLE:  busy = 1'b0;
            S_LOAD: begin
                tmr_load = 1'b1;
                tmr_time = r_t_lat;
                grant    = w_own_oh;
            end
            S_RUN:   grant = w_own_oh;
            S_ABORT: begin
                tmr_load = 1'b1;
                grant    = w_own_oh;
            end
            S_DONE: begin
                grant = w_own_oh;
                done  = w_own_oh;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: vector table for reset/zero-duration, hand sequences with a timer model.
module tb_timer_arbiter;
    localparam int N  = 4;
    localparam int TW = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*TW-1:0] req_time;
    logic [N-1:0]    grant, done, aborted;
    logic            busy, tmr_load, tmr_clr, tmr_timeout;
    logic [TW-1:0]   tmr_time;
    logic [2:0]      dbg_state;

    timer_arbiter #(.N(N), .TW(TW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_time(req_time),
        .grant(grant), .done(done), .aborted(aborted), .busy(busy),
        .tmr_load(tmr_load), .tmr_time(tmr_time), .tmr_clr(tmr_clr),
        .tmr_timeout(tmr_timeout), .o_dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer model: 5 clk ticks per second, sticky time_out cleared by its rst (tmr_clr).
    logic tm_tout, tm_armed;
    int   tm_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tm_tout <= 1'b0; tm_armed <= 1'b0; tm_cnt <= 0;
        end else if (tmr_clr) begin
            tm_tout <= 1'b0; tm_armed <= 1'b0; tm_cnt <= 0;
        end else if (tmr_load) begin
            tm_cnt   <= int'(tmr_time) * 5;
            tm_armed <= (tmr_time != '0);
        end else if (tm_armed) begin
            if (tm_cnt == 1) begin
                tm_tout  <= 1'b1;
                tm_armed <= 1'b0;
            end
            tm_cnt <= tm_cnt - 1;
        end
    end
    assign tmr_timeout = tm_tout;

    int n_checks = 0, n_fail = 0;
    int n_load = 0, n_clr = 0, n_abort = 0;
    logic [N-1:0] prev_done = '0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and run the per-cycle monitor / done scoreboard.
    task automatic tick();
        @(negedge clk);
        check("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
        if (tmr_load) n_load++;
        if (tmr_clr) n_clr++;
        if (aborted != '0) n_abort++;
        if (done != '0) begin
            check("done_one_cycle", 32'(prev_done & done), 32'd0);
            if (exp_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
            else check("done_owner", 32'(done), 32'(exp_q.pop_front()));
        end
        prev_done = done;
    endtask

    task automatic set_time(input int ch, input logic [TW-1:0] v);
        req_time[ch*TW +: TW] = v;
    endtask

    task automatic wait_timeout(input string name);
        int k;
        k = 0;
        while (tmr_timeout !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check($sformatf("%s_timeout_seen", name), 32'(tmr_timeout), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_time = '0;
        repeat (2) @(posedge clk);
        tick();
        check("rst_load", 32'(tmr_load), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_grant", 32'(grant), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("rst_idle_busy", 32'(busy), 32'd0);
    endtask

    // Row: expected outputs of the current cycle, then inputs applied for the next edge.
    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic [TW-1:0] t2;
        logic [N-1:0]  push;
        logic          busy, load, clr;
        logic [TW-1:0] ttime;
        logic [N-1:0]  grant, done;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, ab0, ld0, cl0;
        rst = 1'b1; req = '0; req_time = '0;
        //            rst   req      t2     push     busy  load  clr   ttime  grant    done
        vecs[0] = '{1'b0, 4'b0000, 16'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 16'd0, 4'b0000, 4'b0000};
        vecs[1] = '{1'b0, 4'b0000, 16'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd0, 4'b0000, 4'b0000};
        vecs[2] = '{1'b0, 4'b0000, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b0000};
        vecs[3] = '{1'b0, 4'b0100, 16'd0, 4'b0100, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b0000};
        vecs[4] = '{1'b0, 4'b0000, 16'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 16'd0, 4'b0100, 4'b0100};
        vecs[5] = '{1'b0, 4'b0000, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b0000};
        vecs[6] = '{1'b0, 4'b0000, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b0000};
        repeat (2) @(posedge clk);

        for (int r = 0; r < 7; r++) begin
            tick();
            check($sformatf("vec%0d_busy", r), 32'(busy), 32'(vecs[r].busy));
            check($sformatf("vec%0d_load", r), 32'(tmr_load), 32'(vecs[r].load));
            check($sformatf("vec%0d_clr", r), 32'(tmr_clr), 32'(vecs[r].clr));
            check($sformatf("vec%0d_time", r), 32'(tmr_time), 32'(vecs[r].ttime));
            check($sformatf("vec%0d_grant", r), 32'(grant), 32'(vecs[r].grant));
            check($sformatf("vec%0d_done", r), 32'(done), 32'(vecs[r].done));
            rst = vecs[r].rst;
            req = vecs[r].req;
            set_time(2, vecs[r].t2);
            if (vecs[r].push != '0) exp_q.push_back(vecs[r].push);
        end

        // Single request, 3 s.
        cl0 = n_clr; ld0 = n_load;
        set_time(0, 16'd3); req = 4'b0001; exp_q.push_back(4'b0001);
        tick();
        check("A_load", 32'(tmr_load), 32'd1);
        check("A_time", 32'(tmr_time), 32'd3);
        check("A_grant_load", 32'(grant), 32'b0001);
        tick();
        check("A_grant_run", 32'(grant), 32'b0001);
        check("A_run_load_low", 32'(tmr_load), 32'd0);
        wait_timeout("A");
        tick();
        check("A_clr", 32'(tmr_clr), 32'd1);
        check("A_grant_clr", 32'(grant), 32'b0001);
        check("A_no_done_clr", 32'(done), 32'd0);
        tick();
        check("A_done", 32'(done), 32'b0001);
        req = '0;
        tick();
        check("A_idle_busy", 32'(busy), 32'd0);
        check("A_idle_grant", 32'(grant), 32'd0);
        check("A_clr_count", 32'(n_clr - cl0), 32'd1);
        check("A_load_count", 32'(n_load - ld0), 32'd1);

        // All four channels held: rotation 0,1,2,3,0.
        do_reset();
        for (int c = 0; c < N; c++) set_time(c, 16'd1);
        req = 4'b1111;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        k = 0;
        while (exp_q.size() != 0 && k < 600) begin
            tick();
            k++;
        end
        req = '0;
        check("B_rotation_complete", 32'(exp_q.size()), 32'd0);
        tick();
        check("B_idle_grant", 32'(grant), 32'd0);

        // Channel 3 raised mid-RUN of channel 1 waits for IDLE.
        set_time(1, 16'd2); set_time(3, 16'd1);
        req = 4'b0010; exp_q.push_back(4'b0010);
        tick();
        check("D_grant1_load", 32'(grant), 32'b0010);
        tick(); tick(); tick();
        req = 4'b1010; exp_q.push_back(4'b1000);
        tick();
        check("D_grant_held_run", 32'(grant), 32'b0010);
        check("D_no_load_run", 32'(tmr_load), 32'd0);
        wait_timeout("D1");
        tick();
        check("D_clr", 32'(tmr_clr), 32'd1);
        tick();
        check("D_done1", 32'(done), 32'b0010);
        req = 4'b1000;
        tick();
        check("D_idle_between", 32'(busy), 32'd0);
        tick();
        check("D_grant3_load", 32'(grant), 32'b1000);
        check("D_load3", 32'(tmr_load), 32'd1);
        check("D_time3", 32'(tmr_time), 32'd1);
        wait_timeout("D3");
        tick();
        tick();
        check("D_done3", 32'(done), 32'b1000);
        req = '0;
        tick();

        // Owner drops request four cycles into RUN.
        ab0 = n_abort;
        set_time(0, 16'd3); req = 4'b0001;
`ifndef TIMER_ARB_CANCEL_EN
        exp_q.push_back(4'b0001);
`endif
        tick();
        check("E_grant_load", 32'(grant), 32'b0001);
        repeat (4) tick();
        req = '0;
        tick();
`ifdef TIMER_ARB_CANCEL_EN
        check("E_abort_load", 32'(tmr_load), 32'd1);
        check("E_abort_time", 32'(tmr_time), 32'd0);
        check("E_abort_grant", 32'(grant), 32'b0001);
        tick();
        check("E_abort_clr", 32'(tmr_clr), 32'd1);
        check("E_aborted", 32'(aborted), 32'b0001);
        check("E_no_done", 32'(done), 32'd0);
        tick();
        check("E_idle", 32'(busy), 32'd0);
        check("E_abort_count", 32'(n_abort - ab0), 32'd1);
`else
        check("E_still_run_grant", 32'(grant), 32'b0001);
        check("E_still_run_load", 32'(tmr_load), 32'd0);
        wait_timeout("E");
        tick();
        tick();
        check("E_done_normal", 32'(done), 32'b0001);
        tick();
        check("E_idle", 32'(busy), 32'd0);
        check("E_abort_count", 32'(n_abort - ab0), 32'd0);
`endif
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin scheduler that shares one seconds-countdown timer (load/time_in/rst/time_out interface, 5 clk ticks per second) among N requesters. It latches a winning request, loads the timer, waits for time-out, clears the timer's sticky flag and returns a one-cycle completion pulse to the owner. It sits between the application channels and the single timer instance; the timer sees only this block as its master.

## Interface
Parameters:
- N, 4, number of requesters (2..16)
- TW, 16, time value width in seconds, matching the timer's time_in

Ports:
- clk  in  1  system clock (same clock as the timer)
- rst  in  1  asynchronous, active-high reset
- req  in  N  per-channel request, level; owner holds it until done
- req_time  in  N*TW  per-channel duration, channel i at bits [i*TW +: TW]
- grant  out  N  one-hot owner indicator
- done  out  N  one-cycle completion pulse to the owner
- aborted  out  N  one-cycle cancel-acknowledge pulse (tied 0 without TIMER_ARB_CANCEL_EN)
- busy  out  1  high in every state except IDLE
- tmr_load  out  1  drives timer load
- tmr_time  out  TW  drives timer time_in
- tmr_clr  out  1  drives timer rst (clears time_out)
- tmr_timeout  in  1  timer time_out flag

## Operation
- States: FLUSH, CLEAR, IDLE, LOAD, RUN, ABORT, DONE. All outputs are Moore-decoded from the state register plus the latched owner index `own` and latched time `t_lat`.
- FLUSH: tmr_load=1, tmr_time=0 (disarms any stale countdown) -> CLEAR.
- CLEAR: tmr_clr=1 -> DONE if entered from RUN, else IDLE.
- IDLE: if req != 0, select first set bit scanning from (last+1) mod N upward with wrap; latch own, t_lat=req_time[own]. t_lat==0 -> DONE (timer untouched), else -> LOAD. No request -> stay.
- LOAD: tmr_load=1, tmr_time=t_lat -> RUN.
- RUN: wait tmr_timeout==1 -> CLEAR. Requests from other channels are ignored (not queued; they remain pending on req).
- DONE: done[own]=1; last=own -> IDLE.
- grant[own]=1 in LOAD, RUN, ABORT, CLEAR (when returning to DONE) and DONE; else 0.
- Reset: state=FLUSH, last=N-1 (channel 0 wins first), own=0, t_lat=0. Output values during reset: tmr_load=1, tmr_time=0, busy=1; tmr_clr, grant, done, aborted all 0.

## Timing
- Request sampled in IDLE cycle t: LOAD in t+1, RUN from t+2.
- tmr_timeout first seen high in cycle k: CLEAR in k+1, DONE in k+2, IDLE in k+3; next grant earliest LOAD at k+4.
- Zero-duration request at t: DONE (grant+done) at t+1, IDLE at t+2.
- After reset release: FLUSH 1 cycle, CLEAR 1 cycle, IDLE from 3rd cycle.
- req and req_time are sampled only in IDLE; changes in other states have no effect (except cancel below).
- tmr_timeout outside RUN is ignored.

## Configuration
- TIMER_ARB_CANCEL_EN defined: in RUN, if req[own] is low for a cycle -> ABORT (tmr_load=1, tmr_time=0, grant held) -> CLEAR -> IDLE, with aborted[own]=1 in the CLEAR cycle; done not pulsed; last=own. If tmr_timeout and req[own] drop in the same RUN cycle, timeout wins (normal DONE path).
- Undefined: ABORT state unreachable, aborted tied to 0, req[own] drop in RUN ignored.

## Test plan
- Reset release with no requests -> tmr_load high cycle 1, tmr_clr high cycle 2, busy low from cycle 3, all grant/done 0.
- req=0001, time=3, timer model fires after 15 clk -> grant[0] from LOAD to DONE, done[0] exactly one cycle, 2 cycles after time_out, tmr_clr pulsed once.
- req=1111 held, time=1 each -> service order 0,1,2,3,0, each done one pulse; no two grant bits ever high.
- req[2] with time=0 -> done[2] one cycle after sampling, tmr_load never asserted.
- req[1] granted, req[3] raised mid-RUN -> no effect until IDLE; channel 3 granted next (LOAD 4 cycles after time_out).
- With TIMER_ARB_CANCEL_EN: drop req[0] 4 cycles into RUN -> tmr_load with tmr_time=0, then tmr_clr plus aborted[0], done[0] stays 0; without macro same stimulus -> normal done[0].
